// File: rtl/demux_pkg.sv
// Shared constants and types for the 1:4 valid/ready demultiplexer.
package demux_pkg;

    localparam int LANES         = 4;
    localparam int SEL_W         = 2;
    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_CNT_W = 7;

    typedef logic [SEL_W-1:0] lane_idx_t;

endpackage

// File: rtl/demux_lane.sv
// One output lane: a single-entry buffer with backpressure and a wrapping
// count of words handed to the consumer.
module demux_lane
    import demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic [CNT_W-1:0] count,
    output logic             full
);

    logic drain;

    assign drain = valid & rd_ready;
    assign full  = valid;

    // A write wins over a drain so a same-cycle drain+write keeps valid high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data  <= '0;
            valid <= 1'b0;
            count <= '0;
        end else begin
            if (wr_en) begin
                data  <= wr_data;
                valid <= 1'b1;
            end else if (drain) begin
                valid <= 1'b0;
            end
            if (drain) begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux14_4b.sv
// Registered 1:4 demultiplexer: steers each accepted word to one lane chosen
// by select or by a round-robin pointer.
module demux14_4b
    import demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] select,
    input  logic             rr_mode,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic             out0_valid,
    output logic             out1_valid,
    output logic             out2_valid,
    output logic             out3_valid,
    input  logic             out0_ready,
    input  logic             out1_ready,
    input  logic             out2_ready,
    input  logic             out3_ready,
    output logic [CNT_W-1:0] count0,
    output logic [CNT_W-1:0] count1,
    output logic [CNT_W-1:0] count2,
    output logic [CNT_W-1:0] count3
);

    lane_idx_t        ptr;
    lane_idx_t        target;
    logic             accept;
    logic [LANES-1:0] full;
    logic [LANES-1:0] lane_valid;
    logic [LANES-1:0] rd_ready;
    logic [LANES-1:0] wr_en;
    logic [WIDTH-1:0] lane_data  [LANES];
    logic [CNT_W-1:0] lane_count [LANES];

    assign rd_ready = {out3_ready, out2_ready, out1_ready, out0_ready};
    assign target   = rr_mode ? ptr : select;

    // A full target lane can still take a word if it is draining this cycle.
    assign in_ready = !full[target] | rd_ready[target];
    assign accept   = in_valid & in_ready;

    always_comb begin
        wr_en         = '0;
        wr_en[target] = accept;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (accept && rr_mode) begin
            ptr <= lane_idx_t'(ptr + 2'd1);
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        demux_lane #(
            .WIDTH (WIDTH),
            .CNT_W (CNT_W)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .wr_en    (wr_en[i]),
            .wr_data  (in),
            .rd_ready (rd_ready[i]),
            .data     (lane_data[i]),
            .valid    (lane_valid[i]),
            .count    (lane_count[i]),
            .full     (full[i])
        );
    end

    assign out0       = lane_data[0];
    assign out1       = lane_data[1];
    assign out2       = lane_data[2];
    assign out3       = lane_data[3];
    assign out0_valid = lane_valid[0];
    assign out1_valid = lane_valid[1];
    assign out2_valid = lane_valid[2];
    assign out3_valid = lane_valid[3];
    assign count0     = lane_count[0];
    assign count1     = lane_count[1];
    assign count2     = lane_count[2];
    assign count3     = lane_count[3];

endmodule

// File: tb/tb_demux14_4b.sv
// Scoreboard bench for demux14_4b: stimulus pushes expected words per lane,
// a monitor on the falling edge checks valids, data, counts and in_ready.
module tb_demux14_4b;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] select = '0;
    logic       rr_mode = 1'b0;
    logic [3:0] rdy = '0;
    logic [3:0] out0, out1, out2, out3;
    logic       out0_valid, out1_valid, out2_valid, out3_valid;
    logic [6:0] count0, count1, count2, count3;

    logic [3:0] outs   [4];
    logic       valids [4];
    logic [6:0] counts [4];

    int compared = 0;
    int mismatched = 0;

    logic [3:0] q [4][$];
    logic [6:0] mcount [4];
    logic [1:0] mptr = '0;
    logic       mux_en = 1'b0;
    logic [1:0] mux_sel = '0;
    logic [3:0] mux_stream [$];

    demux14_4b dut (
        .clk        (clk),
        .reset      (reset),
        .in         (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .select     (select),
        .rr_mode    (rr_mode),
        .out0       (out0),
        .out1       (out1),
        .out2       (out2),
        .out3       (out3),
        .out0_valid (out0_valid),
        .out1_valid (out1_valid),
        .out2_valid (out2_valid),
        .out3_valid (out3_valid),
        .out0_ready (rdy[0]),
        .out1_ready (rdy[1]),
        .out2_ready (rdy[2]),
        .out3_ready (rdy[3]),
        .count0     (count0),
        .count1     (count1),
        .count2     (count2),
        .count3     (count3)
    );

    always #5 clk = ~clk;

    assign outs[0] = out0;  assign outs[1] = out1;
    assign outs[2] = out2;  assign outs[3] = out3;
    assign valids[0] = out0_valid;  assign valids[1] = out1_valid;
    assign valids[2] = out2_valid;  assign valids[3] = out3_valid;
    assign counts[0] = count0;  assign counts[1] = count1;
    assign counts[2] = count2;  assign counts[3] = count3;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Falling-edge monitor: drains are popped before the new accept is pushed.
    always @(negedge clk or negedge reset) begin
        logic [1:0] tgt;
        logic       exp_rdy;
        if (!reset) begin
            for (int n = 0; n < 4; n++) begin
                q[n].delete();
                mcount[n] = '0;
            end
            mptr = '0;
        end else begin
            tgt     = rr_mode ? mptr : select;
            exp_rdy = (q[tgt].size() == 0) || rdy[tgt];
            checkOutput("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
            for (int n = 0; n < 4; n++) begin
                checkOutput($sformatf("valid%0d", n), {31'd0, valids[n]}, {31'd0, q[n].size() != 0});
                checkOutput($sformatf("count%0d", n), {25'd0, counts[n]}, {25'd0, mcount[n]});
                if (q[n].size() != 0) begin
                    checkOutput($sformatf("data%0d", n), {28'd0, outs[n]}, {28'd0, q[n][0]});
                    if (rdy[n]) begin
                        if (mux_en && mux_sel == n[1:0]) begin
                            mux_stream.push_back(outs[n]);
                            mux_sel = mux_sel + 2'd1;
                        end
                        void'(q[n].pop_front());
                        mcount[n] = mcount[n] + 7'd1;
                    end
                end
            end
            if (!mux_en) mux_sel = '0;
            if (in_valid && exp_rdy) begin
                q[tgt].push_back(in_data);
                if (rr_mode) mptr = mptr + 2'd1;
            end
        end
    end

    task automatic applyStimulus(input logic [3:0] data, input logic [1:0] sel, input logic rr);
        in_data  = data;
        select   = sel;
        rr_mode  = rr;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        repeat (2) step();
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("rst_valids", {28'd0, out3_valid, out2_valid, out1_valid, out0_valid}, 32'd0);
        reset = 1'b1;

        // Static select into lane 2, no consumers ready.
        applyStimulus(4'hA, 2'd2, 1'b0);
        checkOutput("t1_out2", {28'd0, out2}, 32'hA);
        checkOutput("t1_out2_valid", {31'd0, out2_valid}, 32'd1);
        checkOutput("t1_count2", {25'd0, count2}, 32'd0);

        // Backpressure: 4'h5 waits three cycles behind the held 4'hA.
        in_data = 4'h5; select = 2'd2; in_valid = 1'b1;
        repeat (3) step();
        checkOutput("t2_hold_out2", {28'd0, out2}, 32'hA);
        rdy[2] = 1'b1;
        step();
        in_valid = 1'b0;
        checkOutput("t2_out2", {28'd0, out2}, 32'h5);
        checkOutput("t2_valid2", {31'd0, out2_valid}, 32'd1);
        checkOutput("t2_count2", {25'd0, count2}, 32'd1);
        step();
        checkOutput("t2_count2_after", {25'd0, count2}, 32'd2);

        // Round robin with every consumer ready; tb mux rebuilds the stream.
        rdy = 4'hF;
        mux_en = 1'b1;
        for (int w = 1; w <= 5; w++) applyStimulus(4'(w), 2'd0, 1'b1);
        repeat (2) step();
        mux_en = 1'b0;
        checkOutput("rr_stream_len", mux_stream.size(), 32'd5);
        for (int w = 0; w < mux_stream.size(); w++)
            checkOutput($sformatf("rr_stream%0d", w), {28'd0, mux_stream[w]}, w + 1);
        checkOutput("rr_counts", {count3, count2, count1, count0}, {7'd1, 7'd3, 7'd1, 7'd2});

        // Fill lanes 1 and 3 with ptr ending at 2, then reset between edges.
        rdy = 4'h0;
        applyStimulus(4'h6, 2'd0, 1'b1);
        applyStimulus(4'h7, 2'd3, 1'b0);
        checkOutput("pre_rst_valids", {28'd0, out3_valid, out2_valid, out1_valid, out0_valid}, 32'b1010);
        #1 reset = 1'b0;
        #1;
        checkOutput("mid_rst_valids", {28'd0, out3_valid, out2_valid, out1_valid, out0_valid}, 32'd0);
        checkOutput("mid_rst_outs", {16'd0, out3, out2, out1, out0}, 32'd0);
        checkOutput("mid_rst_counts", {count3, count2, count1, count0}, 28'd0);
        checkOutput("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        reset = 1'b1;
        rr_mode = 1'b1; in_data = 4'h9; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checkOutput("post_rst_lane0", {27'd0, out0_valid, out0}, 32'h19);

        // 128 words into lane 0 plus the held 4'h9: 129 drains, count0 ends at 1.
        rr_mode = 1'b0; select = 2'd0; rdy[0] = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 128; i++) begin
            in_data = 4'(i);
            step();
        end
        in_valid = 1'b0;
        step();
        checkOutput("wrap_count0", {25'd0, count0}, 32'd1);
        checkOutput("wrap_others", {count3, count2, count1}, 21'd0);

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/demux14_4b.md
# demux14_4b

Registered 1:4 demultiplexer with valid/ready handshake, 4-bit data, the receive-side counterpart of the 4:1 valid-mux path. One input word per accepted cycle is steered to one of four output lanes, either by an external `select` or by an internal round-robin pointer. Each lane is a one-entry buffer with backpressure and a wrapping count of words delivered. It sits after the mux stage, fanning a shared stream back out to four consumers.

## Interface
Parameters:
- `WIDTH`, 4, data width of input and each lane
- `CNT_W`, 7, width of each per-lane delivered-word counter

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset (0 = reset)
- `in`  in  WIDTH  input data word
- `in_valid`  in  1  `in` carries a word this cycle
- `in_ready`  out  1  block accepts the word this cycle (combinational)
- `select`  in  2  target lane when `rr_mode`=0
- `rr_mode`  in  1  1 = internal round-robin pointer picks the lane, `select` ignored
- `out0`..`out3`  out  WIDTH each  lane data, registered
- `out0_valid`..`out3_valid`  out  1 each  lane holds an undelivered word
- `out0_ready`..`out3_ready`  in  1 each  lane consumer takes the word this cycle
- `count0`..`count3`  out  CNT_W each  words delivered per lane, wrapping

## Operation
- Target lane `t` = `rr_mode` ? `ptr` : `select`. `ptr` is a 2-bit register.
- Lane `n` is full when `outN_valid`=1. Lane `n` drains when `outN_valid`=1 and `outN_ready`=1.
- `in_ready` = !full[t] | drain[t]. This is combinational from `select`, `rr_mode`, `ptr`, lane state, and `outN_ready`.
- Accept = `in_valid` & `in_ready`.
- On accept: `out[t]` <= `in` and `out[t]_valid` <= 1. If `rr_mode`=1, `ptr` <= `ptr`+1, wrapping 3→0.
- For any lane `n`: drain without a new write gives `outN_valid` <= 0. Data is held, not cleared.
- Drain and write to the same lane in the same cycle: the old word is delivered, the new word is loaded, and valid stays 1.
- `countN` increments by 1 on each drain of lane `n` and wraps from 2^CNT_W−1 to 0.
- `ptr` does not advance when `rr_mode`=0 or when there is no accept. Toggling `rr_mode` does not reset `ptr`.
- Lanes other than `t` are never written. They drain independently in the same cycle.
- `in_valid`=0: no state change except drains.

## Timing
- Reset asserted (`reset`=0), asynchronous: all `outN`=0, `outN_valid`=0, `countN`=0, `ptr`=0. `in_ready` evaluates to 1 while in reset.
- A reset mid-operation discards buffered words immediately. There is no partial count update.
- Reset release is synchronous to the next rising edge. The first accept can happen on the first edge with `reset`=1.
- Latency: a word accepted at edge k is visible on `outN`/`outN_valid` after edge k. It can drain at edge k+1 at the earliest.
- Throughput: 1 word/cycle per lane under continuous ready. Round-robin mode sustains 1 word/cycle across lanes.
- `countN` updates on the edge where the drain occurs.

## Structure
- Package `demux_pkg`:
  - constants `LANES`=4, `SEL_W`=2, default `WIDTH`=4, default `CNT_W`=7
  - a lane-index typedef.
- Sub-module `demux_lane`: one-entry buffer plus counter.
  - Ports: clk, reset, wr_en, wr_data, rd_ready, data, valid, count, full.
  - `demux14_4b` instantiates it 4 times and holds `ptr`, target selection, and `in_ready` logic.

## Test plan
- Reset then static select:
  - Stimulus: `reset`=0 for 2 cycles, then `select`=2, `in`=4'hA, `in_valid`=1, all readys 0.
  - Required: `out2`=4'hA and `out2_valid`=1 after one edge. Other valids stay 0. `in_ready` falls to 0 for lane 2. `count2`=0.
- Backpressure then drain:
  - Stimulus: lane 2 full, new word 4'h5 to lane 2 held for 3 cycles with `out2_ready`=0, then `out2_ready`=1.
  - Required: `out2` stays 4'hA until ready. On that edge `out2`=4'h5, valid stays 1, `count2`=1.
- Round-robin:
  - Stimulus: `rr_mode`=1, all readys 1, inputs 1,2,3,4,5 on consecutive cycles.
  - Required: words land on lanes 0,1,2,3,0. `ptr` wraps to 1. Each `countN` increments one cycle after its write.
- Counter wrap:
  - Stimulus: 128 words to lane 0 with `out0_ready`=1.
  - Required: `count0` goes 127→0. No other counter moves.
- Reset mid-operation:
  - Stimulus: lanes 1 and 3 full, `ptr`=2; pulse `reset` low between edges.
  - Required: immediately all valids=0, outputs=0, counts=0, `ptr`=0. The next round-robin accept goes to lane 0.
- Cross-check:
  - Stimulus: feed the outputs into the existing 4:1 valid mux with a matching `select` sequence.
  - Required: the mux output reproduces the original input stream.
